// File: rtl/sm_uart_rx.sv
// UART receiver, 8N1, LSB first. Start bit is validated at its midpoint and
// every later bit is sampled one bit-time apart, so the stop bit is sampled
// mid-bit and the next start edge can follow immediately.
// Exposes a single-entry rvalid/rready holding register plus one-cycle
// frame_err / overrun pulses.
module sm_uart_rx #(
    parameter int unsigned CLK_HZ = 50000000,
    parameter int unsigned BAUD   = 115200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rdata,
    output logic       rvalid,
    input  logic       rready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int unsigned DIV  = CLK_HZ / BAUD;
    localparam int unsigned HALF = DIV / 2;
    localparam int unsigned CW   = $clog2(DIV);

    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    logic [1:0]    sync_q;
    logic          rx_s;
    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    idx_q;
    logic [7:0]    shift_q;
    logic [7:0]    rdata_q;
    logic          rvalid_q;
    logic          ferr_q;
    logic          ovr_q;
    logic          busy_q;

    assign rx_s = sync_q[1];

    // Two-flop synchronizer, preset to the idle (high) line level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rx};
        end
    end

    // Receive FSM with bit timing, shift register and output holding register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            ferr_q   <= 1'b0;
            ovr_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            ferr_q <= 1'b0;
            ovr_q  <= 1'b0;

            // Consumer handshake; a delivery in the same cycle overrides this.
            if (rvalid_q && rready) begin
                rvalid_q <= 1'b0;
            end

            case (state_q)
                S_IDLE: begin
                    if (!rx_s) begin
                        state_q <= S_START;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end

                S_START: begin
                    if (cnt_q == CNT_HALF) begin
                        cnt_q <= '0;
                        idx_q <= '0;
                        if (rx_s) begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= S_DATA;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end

                S_DATA: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q   <= '0;
                        shift_q <= {rx_s, shift_q[7:1]};
                        idx_q   <= idx_q + 3'd1;
                        if (idx_q == 3'd7) begin
                            state_q <= S_STOP;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end

                S_STOP: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q <= '0;
                        if (rx_s) begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                            if (!rvalid_q || rready) begin
                                rdata_q  <= shift_q;
                                rvalid_q <= 1'b1;
                            end else begin
                                ovr_q <= 1'b1;
                            end
                        end else begin
                            ferr_q  <= 1'b1;
                            state_q <= S_BREAK;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end

                S_BREAK: begin
                    if (rx_s) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign rdata     = rdata_q;
    assign rvalid    = rvalid_q;
    assign frame_err = ferr_q;
    assign overrun   = ovr_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_sm_uart_rx.sv
// Bench for sm_uart_rx at DIV=16, HALF=8. Expected bytes are queued when a
// frame is sent; a monitor pops and compares whenever a new byte is presented.
module tb_sm_uart_rx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx;
    logic       rready;
    logic [7:0] rdata;
    logic       rvalid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    sm_uart_rx #(
        .CLK_HZ(1600000),
        .BAUD  (100000)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx       (rx),
        .rdata    (rdata),
        .rvalid   (rvalid),
        .rready   (rready),
        .frame_err(frame_err),
        .overrun  (overrun),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];
    int fe_cnt = 0;
    int ov_cnt = 0;
    int present_cyc = -1;
    int start_cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drives one 8N1 frame; must be called right at a falling clock edge.
    task automatic send_byte(input logic [7:0] b, input logic stop);
        start_cyc = cyc;
        rx = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (16) @(negedge clk);
        end
        rx = stop;
        repeat (16) @(negedge clk);
    endtask

    task automatic pulse_ready();
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
    endtask

    // Monitor: a new byte is presented when rvalid is high and either the
    // previous cycle had no byte or the previous byte was accepted this edge.
    initial begin
        logic pv;
        logic pfe;
        logic pov;
        logic [7:0] e;
        pv = 1'b0;
        pfe = 1'b0;
        pov = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n) begin
                if (rvalid && (!pv || rready)) begin
                    present_cyc = cyc;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_byte: got %0h expected none (cycle %0d)", rdata, cyc);
                    end else begin
                        e = exp_q.pop_front();
                        check("sb_rdata", 32'(rdata), 32'(e));
                    end
                end
                if (frame_err) begin
                    fe_cnt++;
                    check("frame_err_width", 32'(pfe), 32'd0);
                end
                if (overrun) begin
                    ov_cnt++;
                    check("overrun_width", 32'(pov), 32'd0);
                end
                if (frame_err || overrun) begin
                    check("fe_ov_exclusive", 32'(frame_err & overrun), 32'd0);
                end
            end
            pv = rvalid;
            pfe = frame_err;
            pov = overrun;
        end
    end

    initial begin
        repeat (50000) @(posedge clk);
        $display("FAIL watchdog: got timeout expected completion (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        int s;
        logic seen;

        rst_n = 1'b0;
        rx = 1'b1;
        rready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_rdata", 32'(rdata), 32'h00);
        check("rst_rvalid", 32'(rvalid), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Single frame 0xA5, latency, then consume.
        exp_q.push_back(8'hA5);
        send_byte(8'hA5, 1'b1);
        lat = present_cyc - start_cyc;
        checks++;
        if (lat < 153 || lat > 157) begin
            errors++;
            $display("FAIL a5_latency: got %0d expected 153..157", lat);
        end
        check("a5_rdata", 32'(rdata), 32'hA5);
        check("a5_rvalid", 32'(rvalid), 32'd1);
        pulse_ready();
        repeat (2) @(negedge clk);
        check("a5_rvalid_cleared", 32'(rvalid), 32'd0);
        check("a5_queue_empty", 32'(exp_q.size()), 32'd0);

        // Short low glitch rejected at the start-bit midpoint.
        seen = 1'b0;
        rx = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (busy) seen = 1'b1;
        end
        rx = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (busy) seen = 1'b1;
        end
        check("glitch_busy_rose", 32'(seen), 32'd1);
        repeat (20) @(negedge clk);
        check("glitch_busy_idle", 32'(busy), 32'd0);
        check("glitch_rvalid", 32'(rvalid), 32'd0);
        check("glitch_fe_cnt", 32'(fe_cnt), 32'd0);
        check("glitch_ov_cnt", 32'(ov_cnt), 32'd0);

        // Bad stop bit followed by a long break.
        send_byte(8'h3C, 1'b0);
        rx = 1'b0;
        repeat (40 * 16) @(negedge clk);
        check("break_fe_cnt", 32'(fe_cnt), 32'd1);
        check("break_busy", 32'(busy), 32'd1);
        check("break_rvalid", 32'(rvalid), 32'd0);
        rx = 1'b1;
        repeat (5) @(negedge clk);
        check("break_busy_released", 32'(busy), 32'd0);
        check("break_fe_cnt_after", 32'(fe_cnt), 32'd1);

        // Back-to-back 0x11, 0x22 with no consumer: second byte overruns.
        exp_q.push_back(8'h11);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        repeat (10) @(negedge clk);
        check("ovr_rdata", 32'(rdata), 32'h11);
        check("ovr_rvalid", 32'(rvalid), 32'd1);
        check("ovr_ov_cnt", 32'(ov_cnt), 32'd1);
        pulse_ready();
        repeat (2) @(negedge clk);
        check("ovr_rvalid_cleared", 32'(rvalid), 32'd0);
        check("ovr_queue_empty", 32'(exp_q.size()), 32'd0);

        // Back-to-back 0x55, 0xAA; rready lands on the 0xAA delivery edge.
        exp_q.push_back(8'h55);
        exp_q.push_back(8'hAA);
        send_byte(8'h55, 1'b1);
        s = cyc;
        fork
            send_byte(8'hAA, 1'b1);
            begin
                while (cyc < s + 154) @(negedge clk);
                rready = 1'b1;
                @(negedge clk);
                rready = 1'b0;
            end
        join
        repeat (5) @(negedge clk);
        check("same_cycle_rdata", 32'(rdata), 32'hAA);
        check("same_cycle_rvalid", 32'(rvalid), 32'd1);
        check("same_cycle_ov_cnt", 32'(ov_cnt), 32'd1);
        check("same_cycle_queue_empty", 32'(exp_q.size()), 32'd0);
        pulse_ready();
        repeat (2) @(negedge clk);
        check("same_cycle_rvalid_cleared", 32'(rvalid), 32'd0);

        // Reset during data bit 3 of 0xFF, then 0x0F.
        s = cyc;
        fork
            send_byte(8'hFF, 1'b1);
            begin
                while (cyc < s + 72) @(negedge clk);
                rst_n = 1'b0;
                @(negedge clk);
                check("midrst_rdata", 32'(rdata), 32'h00);
                check("midrst_rvalid", 32'(rvalid), 32'd0);
                check("midrst_frame_err", 32'(frame_err), 32'd0);
                check("midrst_overrun", 32'(overrun), 32'd0);
                check("midrst_busy", 32'(busy), 32'd0);
                repeat (3) @(negedge clk);
                rst_n = 1'b1;
            end
        join
        repeat (5) @(negedge clk);
        check("midrst_idle_after", 32'(busy), 32'd0);
        exp_q.push_back(8'h0F);
        send_byte(8'h0F, 1'b1);
        repeat (5) @(negedge clk);
        check("after_rst_rdata", 32'(rdata), 32'h0F);
        check("after_rst_rvalid", 32'(rvalid), 32'd1);
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        check("final_fe_cnt", 32'(fe_cnt), 32'd1);
        check("final_ov_cnt", 32'(ov_cnt), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
